// File: rtl/leaf_stage_pkg.sv
// -----------------------------------------------------------------------------
// leaf_stage_pkg
// Shared definitions for the leaf stage FIFO slice.
//   LEAF_DATA_W / LEAF_DEPTH : default payload width and entry count
//   LEAF_PTR_W               : pointer width for the default depth
//   leaf_ptr_w()             : pointer width for an arbitrary depth
//                              (index bits plus one wrap bit)
//   leaf_op_e                : per-cycle transfer kind, drives the count update
// -----------------------------------------------------------------------------
package leaf_stage_pkg;

    localparam int unsigned LEAF_DATA_W = 8;
    localparam int unsigned LEAF_DEPTH  = 4;
    localparam int unsigned LEAF_PTR_W  = $clog2(LEAF_DEPTH) + 1;

    function automatic int unsigned leaf_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } leaf_op_e;

endpackage

// File: rtl/leaf_stage_ram.sv
// -----------------------------------------------------------------------------
// leaf_stage_ram
// Storage array for leaf_stage_fifo: one synchronous write port, one
// asynchronous read port, no reset (contents are undefined until written).
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write payload
//   raddr : read index
//   rdata : combinational read payload
// -----------------------------------------------------------------------------
module leaf_stage_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/leaf_stage_fifo.sv
// -----------------------------------------------------------------------------
// leaf_stage_fifo
// First-word fall-through FIFO with valid/ready handshakes on both sides.
//   clk       : clock, all state updates on rising edge
//   rst       : asynchronous active-high reset (pointers and count to 0)
//   clear     : synchronous flush, wins over push and pop in the same cycle
//   in_valid  : upstream offers in_data
//   in_ready  : entry can be accepted this cycle (!full)
//   in_data   : upstream payload
//   out_valid : head entry available (!empty)
//   out_ready : downstream takes the head entry
//   out_data  : head entry payload (don't-care while out_valid=0)
//   count     : number of stored entries
//   full      : count == DEPTH
//   empty     : count == 0
// -----------------------------------------------------------------------------
module leaf_stage_fifo
    import leaf_stage_pkg::*;
#(
    parameter int unsigned DATA_W = LEAF_DATA_W,
    parameter int unsigned DEPTH  = LEAF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W  = leaf_ptr_w(DEPTH);
    localparam int unsigned ADDR_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_q;
    logic             push;
    logic             pop;
    leaf_op_e         op;

    // Flags come only from registered state, so in_ready/out_valid never
    // depend combinationally on the opposite handshake.
    assign full      = (count_q == DEPTH_P);
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    always_comb begin
        op = OP_IDLE;
        unique case ({pop, push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
    end

    // Pointers carry one extra wrap bit; the low ADDR_W bits index storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case (op)
                OP_PUSH: count_q <= count_q + PTR_W'(1);
                OP_POP:  count_q <= count_q - PTR_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A write during clear is harmless to correctness but is suppressed so
    // the flushed cycle leaves storage untouched.
    leaf_stage_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push && !clear),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_leaf_stage_fifo.sv
// -----------------------------------------------------------------------------
// tb_leaf_stage_fifo
// Directed bench for leaf_stage_fifo. A queue holds the words the FIFO should
// contain; each cycle the DUT flags, count and head word are compared with it
// before the clock edge, then the queue is updated from the handshakes.
// -----------------------------------------------------------------------------
module tb_leaf_stage_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    count;
    logic          full;
    logic          empty;

    int unsigned   checks   = 0;
    int unsigned   failures = 0;
    logic [DW-1:0] sb[$];

    leaf_stage_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int unsigned n;
        n = sb.size();
        chk({tag, " count"},     32'(count),     32'(n));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, " in_ready"},  32'(in_ready),  32'(n != DEPTH));
        chk({tag, " full"},      32'(full),      32'(n == DEPTH));
        chk({tag, " empty"},     32'(empty),     32'(n == 0));
        if (n != 0) begin
            chk({tag, " out_data"}, 32'(out_data), 32'(sb[0]));
        end
    endtask

    // Called at posedge+1: drive inputs, check state, then advance one edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic clr, input string tag);
        int unsigned n;
        logic        acc_in;
        logic        acc_out;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        n         = sb.size();
        check_state(tag);
        acc_in  = iv && (n < DEPTH);
        acc_out = ordy && (n > 0);
        @(posedge clk);
        if (clr) begin
            sb.delete();
        end else begin
            if (acc_out) void'(sb.pop_front());
            if (acc_in)  sb.push_back(d);
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single transfer
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, "single_push");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_head");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_after");

        // fill with backpressure, fifth word rejected
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
        end
        chk("fill full_const", 32'(full), 32'd1);
        chk("fill count_const", 32'(count), 32'd4);

        // full: pop and push together, push refused
        cycle(1'b1, 8'h06, 1'b1, 1'b0, "full_pushpop");
        chk("full_pushpop count_const", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("drain%0d", i));
        end

        // streaming through pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0, $sformatf("stream%0d", i));
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "stream_drain");

        // clear beats a same-cycle push
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, $sformatf("preclr%0d", i));
        end
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, "clear");
        chk("clear empty_const", 32'(empty), 32'd1);
        cycle(1'b1, 8'h33, 1'b0, 1'b0, "postclr_push");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "postclr_head");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, "postclr_idle");

        // asynchronous reset between edges with two entries held
        cycle(1'b1, 8'h41, 1'b0, 1'b0, "prerst0");
        cycle(1'b1, 8'h42, 1'b0, 1'b0, "prerst1");
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        sb.delete();
        check_state("async_rst");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("postrst_idle");
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, "postrst_push");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "postrst_head");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, "postrst_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
